// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Tracks outstanding imem/dmem requests, drives the global advance enable,
// per-stage hold/bubble/flush controls and request issue gating.
module pipeline_stall_ctrl #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_resp,
  input  logic             dmem_resp,
  input  logic             dmem_req,
  input  logic             load_use,
  input  logic             br_flush,
  input  logic             fetch_halt,
  output logic [2:0]       state_o,
  output logic             pipe_adv,
  output logic             imem_issue,
  output logic             dmem_issue,
  output logic             pc_hold,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             resp_err,
  output logic             hang_err
);

  // Encoding carries the pending set: bit0 = imem pending, bit1 = dmem pending.
  typedef enum logic [2:0] {
    MOVING    = 3'b000,
    WAIT_IMEM = 3'b001,
    WAIT_DMEM = 3'b010,
    IMEM_DMEM = 3'b011,
    IDLE      = 3'b100
  } stall_state_t;

  localparam int unsigned WC_W = $clog2(TIMEOUT + 1) + 1;

  stall_state_t    state, state_d;
  logic            is_idle;
  logic            imem_pend;
  logic            dmem_pend;
  logic            stalled;
  logic [WC_W-1:0] wait_cnt;

  assign is_idle   = (state == IDLE);
  assign imem_pend = state[0];
  assign dmem_pend = state[1];
  assign state_o   = state;

  // Advance enable, issue gating and hazard controls.
  always_comb begin
    pipe_adv   = !is_idle && (!imem_pend || imem_resp) && (!dmem_pend || dmem_resp);
    imem_issue = (pipe_adv && !fetch_halt) || (is_idle && !rst && !fetch_halt);
    dmem_issue = pipe_adv && dmem_req;
    flush_id   = pipe_adv && br_flush;
    bubble_ex  = pipe_adv && (br_flush || load_use);
    pc_hold    = pipe_adv && load_use && !br_flush;
    stalled    = !is_idle && !pipe_adv;
  end

  // Next state: new pending set from issues on advance, otherwise retire
  // flags of ports that responded (state bits are the pending flags).
  always_comb begin
    state_d = state;
    if (is_idle) begin
      state_d = fetch_halt ? MOVING : WAIT_IMEM;
    end else if (pipe_adv) begin
      state_d = stall_state_t'({1'b0, dmem_issue, imem_issue});
    end else begin
      state_d = stall_state_t'({1'b0, dmem_pend && !dmem_resp, imem_pend && !imem_resp});
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Saturating stall counter and sticky unexpected-response flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      resp_err  <= 1'b0;
    end else begin
      if (stalled && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if ((imem_resp && !imem_pend) || (dmem_resp && !dmem_pend)) resp_err <= 1'b1;
    end
  end

  // Pending-time watchdog; counter freezes once it trips.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      hang_err <= 1'b0;
    end else if (stalled && (imem_pend || dmem_pend)) begin
      if (wait_cnt >= WC_W'(TIMEOUT)) hang_err <= 1'b1;
      else                            wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: stimulus pushes hand-computed
// expected outputs per cycle, a monitor pops and compares at negedge.
module tb_pipeline_stall_ctrl;

  localparam int unsigned TMO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_resp = 1'b0, dmem_resp = 1'b0, dmem_req = 1'b0;
  logic        load_use = 1'b0, br_flush = 1'b0, fetch_halt = 1'b0;
  logic [2:0]  state_o;
  logic        pipe_adv, imem_issue, dmem_issue, pc_hold, bubble_ex, flush_id;
  logic [31:0] stall_cnt;
  logic        resp_err, hang_err;

  pipeline_stall_ctrl #(.TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_resp(dmem_resp),
    .dmem_req(dmem_req), .load_use(load_use), .br_flush(br_flush),
    .fetch_halt(fetch_halt), .state_o(state_o), .pipe_adv(pipe_adv),
    .imem_issue(imem_issue), .dmem_issue(dmem_issue), .pc_hold(pc_hold),
    .bubble_ex(bubble_ex), .flush_id(flush_id), .stall_cnt(stall_cnt),
    .resp_err(resp_err), .hang_err(hang_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [10:0] vec;  // state, pa, ii, di, ph, be, fi, re, he
    logic [31:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // in: {rst, imem_resp, dmem_resp, dmem_req, load_use, br_flush, fetch_halt}
  // fl: {pipe_adv, imem_issue, dmem_issue, pc_hold, bubble_ex, flush_id, resp_err, hang_err}
  task automatic step(input string nm, input logic [6:0] in, input logic [2:0] st,
                      input logic [7:0] fl, input int sc);
    exp_t e;
    @(posedge clk);
    #1;
    {rst, imem_resp, dmem_resp, dmem_req, load_use, br_flush, fetch_halt} = in;
    e.name = nm;
    e.vec  = {st, fl};
    e.sc   = sc;
    exp_q.push_back(e);
  endtask

  // Monitor: compare whatever the stimulus expects for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [10:0] act;
      e   = exp_q.pop_front();
      act = {state_o, pipe_adv, imem_issue, dmem_issue, pc_hold, bubble_ex,
             flush_id, resp_err, hang_err};
      checks++;
      if (act !== e.vec || stall_cnt !== e.sc) begin
        errors++;
        $display("FAIL %s: got st/pa/ii/di/ph/be/fi/re/he=%b cnt=%0d, want %b cnt=%0d",
                 e.name, act, stall_cnt, e.vec, e.sc);
      end
    end
  end

  initial begin
    step("reset",        7'b1000000, 3'b100, 8'b00000000, 0);
    step("idle_fetch",   7'b0000000, 3'b100, 8'b01000000, 0);
    step("first_adv",    7'b0101000, 3'b001, 8'b11100000, 0);
    step("both_wait",    7'b0000000, 3'b011, 8'b00000000, 0);
    step("dmem_first",   7'b0010000, 3'b011, 8'b00000000, 1);
    step("imem_left",    7'b0000000, 3'b001, 8'b00000000, 2);
    step("load_use",     7'b0100100, 3'b001, 8'b11011000, 3);
    step("lu_released",  7'b0100000, 3'b001, 8'b11000000, 3);
    step("flush_prio",   7'b0100110, 3'b001, 8'b11001100, 3);
    step("stray_dresp",  7'b0010000, 3'b001, 8'b00000000, 3);
    // Stall cycles k=1..20 after the stray response; watchdog not yet tripped.
    for (int c = 10; c <= 29; c++)
      step("hang_wait", 7'b0000000, 3'b001, 8'b00000010, 3 + (c - 9));
    step("hang_set",     7'b0000000, 3'b001, 8'b00000011, 24);
    step("adv_after",    7'b0101000, 3'b001, 8'b11100011, 25);
    step("both_resp",    7'b0110000, 3'b011, 8'b11000011, 25);
    step("reissue",      7'b0101000, 3'b001, 8'b11100011, 25);
    step("pre_rst",      7'b0000000, 3'b011, 8'b00000011, 25);
    step("rst_mid",      7'b1000000, 3'b100, 8'b00000000, 0);
    step("late_resp",    7'b0010001, 3'b100, 8'b00000000, 0);
    step("halt_mov1",    7'b0000001, 3'b000, 8'b10000010, 0);
    step("halt_mov2",    7'b0000001, 3'b000, 8'b10000010, 0);
    step("mov_issue",    7'b0001000, 3'b000, 8'b11100010, 0);
    step("imem_first",   7'b0100000, 3'b011, 8'b00000010, 0);
    step("dmem_last",    7'b0010000, 3'b010, 8'b11000010, 1);
    step("wait_imem",    7'b0000000, 3'b001, 8'b00000010, 1);
    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
